// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Brief    : Circular FIFO of {instruction, PC, PC+4} between fetch and decode,
//            with a valid/ready handshake on both sides and a pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int          DEPTH = 2,
  parameter int          PTR_W = 1,
  parameter logic [31:0] NOP   = 32'h00000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      InstructionIn,
  input  logic [31:0]      PCNowIn,
  input  logic [31:0]      PCNext4In,
  input  logic             InValid,
  output logic             InReady,
  input  logic             Flush,
  output logic [31:0]      OutInstruction,
  output logic [31:0]      OutPCNow,
  output logic [31:0]      OutPCNext4,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0] c_depth = DEPTH[PTR_W:0];

  logic [95:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic [95:0]      w_head;

  // Handshake flags depend on registered count only, so no OutReady->InReady path.
  assign InReady  = (r_count < c_depth);
  assign OutValid = (r_count != '0);
  assign Count    = r_count;

  assign w_push = InValid & InReady;
  assign w_pop  = OutValid & OutReady;

  assign w_head         = r_mem[r_rptr];
  assign OutInstruction = OutValid ? w_head[95:64] : NOP;
  assign OutPCNow       = OutValid ? w_head[63:32] : 32'h0;
  assign OutPCNext4     = OutValid ? w_head[31:0]  : 32'h0;

  // Storage is not reset; the OutValid mask keeps stale words off the outputs.
  always_ff @(posedge Clk) begin
    if (Reset && !Flush && w_push) begin
      r_mem[r_wptr] <= {InstructionIn, PCNowIn, PCNext4In};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (Flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the instruction fetch unit and the decode stage.
- Captures each fetched {instruction, PC, PC+4} triple into a small circular FIFO.
- Presents the oldest entry to decode under a valid/ready handshake.
- Supports a pipeline flush for taken jumps/branches; outputs a MIPS NOP (32'h00000000) bubble when empty.

Parameters:
- DEPTH, 2, number of entries; power of two, 2..8.
- PTR_W, 1, pointer width; equals log2(DEPTH).
- NOP, 32'h00000000, instruction word driven when no valid entry (sll $0,$0,0).

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on rising Clk edge.
- InstructionIn  input  32  instruction word from fetch.
- PCNowIn  input  32  PC of that instruction.
- PCNext4In  input  32  PC+4 of that instruction.
- InValid  input  1  fetch presents a valid triple this cycle.
- InReady  output  1  queue can accept; fetch advances its PC only when InValid&InReady.
- Flush  input  1  discard all queued and incoming entries.
- OutInstruction  output  32  head instruction, or NOP when empty.
- OutPCNow  output  32  head PC, or 0 when empty.
- OutPCNext4  output  32  head PC+4, or 0 when empty.
- OutValid  output  1  head entry valid.
- OutReady  input  1  decode consumes head this cycle.
- Count  output  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH entries of 96 bits, plus write pointer, read pointer and Count, all registered.
- push = InValid & InReady.
- pop = OutValid & OutReady.
- InReady = (Count < DEPTH). It is a function of registered state only; there is no combinational path from OutReady.
- OutValid = (Count != 0).
- Out* fields are read combinationally from the entry at the read pointer; when OutValid=0 they are forced to NOP/0/0.
- Latency: an entry pushed at edge N is visible on Out* after edge N; one-cycle minimum fetch-to-decode latency, no bypass.
- Pointers wrap modulo DEPTH. Count increments on push-only, decrements on pop-only, and is unchanged on push&pop.
- Full (Count==DEPTH): InReady=0, so InValid is ignored. A pop in this cycle frees a slot, and InReady rises the following cycle.
- Empty (Count==0): pop cannot occur. A push makes OutValid=1 on the next cycle.
- Priority at each rising edge: Reset==0 > Flush==1 > normal push/pop.
- Reset==0: pointers=0, Count=0, so OutValid=0, Out*=NOP/0/0, InReady=1. Storage contents are don't-care.
- Reset applied mid-operation discards all entries in the same edge.
- Flush==1: pointers=0, Count=0. Any simultaneous push or pop is dropped. On the next cycle OutValid=0 and Out*=NOP.
- Flush held for several cycles keeps the queue empty; InReady stays 1 throughout.
- No X propagation: stale storage is never visible on Out* while OutValid=0.

Test Plan:
- Reset: hold Reset=0 for 2 edges with InValid=1 -> Count=0, OutValid=0, OutInstruction=32'h00000000, InReady=1. Release; push {32'h20080005, 32'h0, 32'h4} -> next cycle OutValid=1, OutInstruction=32'h20080005, OutPCNext4=32'h4.
- Fill/full: OutReady=0, push 0x11111111 at PC 0x0, then 0x22222222 at PC 0x4 -> Count=2, InReady=0. A third push of 0x33333333 is ignored, and the head remains 0x11111111.
- Drain order: from the full state, OutReady=1 with no push -> outputs 0x11111111 then 0x22222222 on consecutive cycles, then OutValid=0 and Count=0.
- Streaming: InValid=1 and OutReady=1 continuously, with PCs 0x0, 0x4, 0x8, 0xC -> Count holds at 1 and OutPCNow follows each PC one cycle after its push. Pointers wrap without loss over 10+ words.
- Flush: queue holds 2 entries; assert Flush with InValid=1 and OutReady=1 in the same cycle -> next cycle Count=0, OutValid=0, OutInstruction=NOP. Then push target 0x00400020 -> visible the following cycle.
- Reset vs flush/mid-stream: Reset=0 and Flush=1 together with 1 entry queued -> empty state identical to reset. Apply Reset=0 for one edge mid-streaming -> the queue empties and resumes cleanly on the next push.
